// File: rtl/idp_enc_16.sv
// idp_enc_16: sequential greedy MSB-first encoder for the 16-wire IDP Fibonacci-numeral crosstalk-avoidance code.
// Optional input range check: define IDP_ENC_16_ERRCHK_EN to drive err from (in_data > MAXVAL).
`ifndef IBLEN16
`define IBLEN16 12
`endif

module idp_enc_16 #(
  parameter int STEPS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [`IBLEN16-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         codeout,
  output logic                err
);

  localparam int IW   = `IBLEN16;
  localparam int NCYC = 16 / STEPS;

  typedef logic [IW:0] rem_t;

  // Fibonacci numerals, FNS1 = FNS2 = 1.
  localparam int FNS1  = 1;
  localparam int FNS2  = 1;
  localparam int FNS3  = 2;
  localparam int FNS4  = 3;
  localparam int FNS5  = 5;
  localparam int FNS6  = 8;
  localparam int FNS7  = 13;
  localparam int FNS8  = 21;
  localparam int FNS9  = 34;
  localparam int FNS10 = 55;
  localparam int FNS11 = 89;
  localparam int FNS12 = 144;
  localparam int FNS13 = 233;
  localparam int FNS15 = 610;
  localparam int FNS16 = 987;

`ifdef IDP_ENC_16_ERRCHK_EN
  localparam int MAXVAL = FNS15 + 2 * FNS16 + FNS13 + FNS12 + FNS11 + FNS10 + FNS9 + FNS8
                        + FNS7 + FNS6 + FNS5 + FNS4 + FNS3 + FNS2 + FNS1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state;
  rem_t        rem;
  rem_t        rem_nxt;
  logic [15:0] code;
  logic [15:0] code_nxt;
  logic [4:0]  cnt;
  logic [3:0]  idx;
  rem_t        w;
  logic        load;

  // Weight of the codeword bit resolved at position 'ord' of the descending-weight order.
  function automatic rem_t weight_of(input logic [3:0] ord);
    case (ord)
      4'd0:    weight_of = rem_t'(FNS16);
      4'd1:    weight_of = rem_t'(FNS16);
      4'd2:    weight_of = rem_t'(FNS15);
      4'd3:    weight_of = rem_t'(FNS13);
      4'd4:    weight_of = rem_t'(FNS12);
      4'd5:    weight_of = rem_t'(FNS11);
      4'd6:    weight_of = rem_t'(FNS10);
      4'd7:    weight_of = rem_t'(FNS9);
      4'd8:    weight_of = rem_t'(FNS8);
      4'd9:    weight_of = rem_t'(FNS7);
      4'd10:   weight_of = rem_t'(FNS6);
      4'd11:   weight_of = rem_t'(FNS5);
      4'd12:   weight_of = rem_t'(FNS4);
      4'd13:   weight_of = rem_t'(FNS3);
      4'd14:   weight_of = rem_t'(FNS2);
      default: weight_of = rem_t'(FNS1);
    endcase
  endfunction

  // Codeword bit position for each step of the resolve order: 14, 13, 15, 12, then 11 down to 0.
  function automatic logic [3:0] pos_of(input logic [3:0] ord);
    case (ord)
      4'd0:    pos_of = 4'd14;
      4'd1:    pos_of = 4'd13;
      4'd2:    pos_of = 4'd15;
      4'd3:    pos_of = 4'd12;
      default: pos_of = 4'd15 - ord;
    endcase
  endfunction

  // Chain STEPS greedy compare/subtract stages off the current remainder.
  always_comb begin
    rem_nxt  = rem;
    code_nxt = code;
    idx      = '0;
    w        = '0;
    for (int j = 0; j < STEPS; j++) begin
      idx = 4'(int'(cnt) * STEPS + j);
      w   = weight_of(idx);
      if (rem_nxt >= w) begin
        rem_nxt               = rem_nxt - w;
        code_nxt[pos_of(idx)] = 1'b1;
      end
    end
  end

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign load     = in_valid && in_ready;
  assign codeout  = code;

  // A load from IDLE or from an accepting HOLD restarts the word; otherwise step RUN or wait in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      code      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      state     <= RUN;
      rem       <= {1'b0, in_data};
      code      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          rem  <= rem_nxt;
          code <= code_nxt;
          if (cnt == 5'(NCYC - 1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IDP_ENC_16_ERRCHK_EN
  logic err_q;

  // Range flag is captured with the word and rides along until the codeword is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load) begin
      err_q <= ({1'b0, in_data} > rem_t'(MAXVAL));
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
